// File: rtl/branch_tag_scheduler_if.sv
// ---------------------------------------------------------------------------
// branch_tag_scheduler_if
//   Bundles the dispatch-side grant signals and the execute-side resolve /
//   recovery signals of the branch-tag scheduler.
//   Parameters: N (dispatch width), BM_W (number of branch tags).
//   Modports:
//     master : drives br_req and resolve_*, observes grants and recovery.
//     slave  : the scheduler itself.
//   Signals:
//     br_req          slot i is a branch wanting a tag
//     br_gnt          slot i granted (prefix-contiguous)
//     gnt_tag         one-hot tag per granted slot (gnt_tag[i] for slot i)
//     tag_stall_slot  first slot denied a tag, N when none denied
//     b_mask          registered outstanding-tag mask
//     resolve_valid / resolve_tag / resolve_mispred   branch resolution
//     restore_valid / restore_tag / squash_mask        recovery pulse
//     clear_mask      tags correctly resolved last cycle
//     dispatch_stall  block all dispatch this cycle
// ---------------------------------------------------------------------------
interface branch_tag_scheduler_if #(
    parameter int N    = 3,
    parameter int BM_W = 4
);
    localparam int SLOT_W = $clog2(N + 1);

    logic [N-1:0]            br_req;
    logic [N-1:0]            br_gnt;
    logic [N-1:0][BM_W-1:0]  gnt_tag;
    logic [SLOT_W-1:0]       tag_stall_slot;
    logic [BM_W-1:0]         b_mask;
    logic                    resolve_valid;
    logic [BM_W-1:0]         resolve_tag;
    logic                    resolve_mispred;
    logic                    restore_valid;
    logic [BM_W-1:0]         restore_tag;
    logic [BM_W-1:0]         squash_mask;
    logic [BM_W-1:0]         clear_mask;
    logic                    dispatch_stall;

    modport master (
        output br_req, resolve_valid, resolve_tag, resolve_mispred,
        input  br_gnt, gnt_tag, tag_stall_slot, b_mask, restore_valid,
               restore_tag, squash_mask, clear_mask, dispatch_stall
    );

    modport slave (
        input  br_req, resolve_valid, resolve_tag, resolve_mispred,
        output br_gnt, gnt_tag, tag_stall_slot, b_mask, restore_valid,
               restore_tag, squash_mask, clear_mask, dispatch_stall
    );
endinterface

// File: rtl/branch_tag_scheduler.sv
// ---------------------------------------------------------------------------
// branch_tag_scheduler
//   Allocates branch tags (B_MASK bits) to dispatch slots in slot order,
//   tracks which older tags each tag depends on, frees tags on correct
//   resolution and, on a mispredict, squashes the tag and its dependents and
//   runs a short recovery sequence that stalls dispatch.
//   Ports:
//     clock   rising-edge clock
//     reset   synchronous, active-high
//     io_bus  branch_tag_scheduler_if.slave (grant, resolve, recovery)
//   Optional build macro BR_TAG_STATS_EN adds:
//     o_stat_full_cycles [31:0]  cycles with a branch denied a tag (saturating)
//     o_stat_recoveries  [15:0]  restore pulses issued (saturating)
// ---------------------------------------------------------------------------
module branch_tag_scheduler #(
    parameter int N           = 3,
    parameter int BM_W        = 4,
    parameter int RECOVER_CYC = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    branch_tag_scheduler_if.slave  io_bus
`ifdef BR_TAG_STATS_EN
    ,
    output logic [31:0]            o_stat_full_cycles,
    output logic [15:0]            o_stat_recoveries
`endif
);
    localparam int SLOT_W = $clog2(N + 1);
    localparam int CNT_W  = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

    typedef enum logic {ST_IDLE, ST_RECOVER} state_t;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [BM_W-1:0]    r_b_mask;
    logic [BM_W-1:0]    r_dep [BM_W];
    logic               r_restore_valid;
    logic [BM_W-1:0]    r_restore_tag;
    logic [BM_W-1:0]    r_squash_mask;
    logic [BM_W-1:0]    r_clear_mask;

    logic               w_res_hit, w_mispred, w_correct, w_dispatch_stall, w_block;
    logic [BM_W-1:0]    w_clear, w_kill, w_taken;
    logic [N-1:0]       w_gnt;
    logic [N-1:0][BM_W-1:0] w_gnt_tag;
    logic [BM_W-1:0]    w_slot_dep [N];
    logic [SLOT_W-1:0]  w_stall_slot;
    logic [BM_W-1:0]    w_b_mask_next;
    logic [BM_W-1:0]    w_dep_next [BM_W];

    // Resolves only act on tags that are still outstanding; anything else
    // (never allocated, or already squashed) is dropped.
    assign w_res_hit = io_bus.resolve_valid && ((io_bus.resolve_tag & r_b_mask) != '0);
    assign w_mispred = w_res_hit &  io_bus.resolve_mispred;
    assign w_correct = w_res_hit & ~io_bus.resolve_mispred;
    assign w_clear   = w_correct ? io_bus.resolve_tag : '0;

    // Squash set: the mispredicted tag plus every tag allocated under it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_kill = '0;
        if (w_mispred) begin
            w_kill = io_bus.resolve_tag;
            for (int j = 0; j < BM_W; j++) begin
                if ((r_dep[j] & io_bus.resolve_tag) != '0) w_kill[j] = 1'b1;
            end
        end
        w_kill = w_kill & r_b_mask;
    end

    // Recovery FSM: RECOVER lasts RECOVER_CYC cycles starting with the
    // restore pulse; a new mispredict on a surviving tag restarts it.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_dispatch_stall = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_dispatch_stall = io_bus.resolve_valid & io_bus.resolve_mispred;
            end
            ST_RECOVER: begin
                w_dispatch_stall = 1'b1;
                if (r_cnt == CNT_W'(RECOVER_CYC - 1)) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_mispred) begin
            w_state_next = ST_RECOVER;
            w_cnt_next   = '0;
        end
        if (reset) w_dispatch_stall = 1'b0;
    end

    assign w_block = w_dispatch_stall | reset
                   | (io_bus.resolve_valid & io_bus.resolve_mispred);

    // Grant walk: free tags come only from the registered mask, so a tag
    // freed this cycle cannot be handed out until the next one.
    always_comb begin
        logic [BM_W-1:0] avail;
        logic [BM_W-1:0] pick;
        logic            denied;
        avail        = ~r_b_mask;
        pick         = '0;
        denied       = 1'b0;
        w_taken      = '0;
        w_gnt        = '0;
        w_gnt_tag    = '0;
        w_stall_slot = SLOT_W'(N);
        for (int i = 0; i < N; i++) begin
            w_slot_dep[i] = '0;
            if (io_bus.br_req[i] && !denied) begin
                if (avail != '0) begin
                    pick          = avail & (~avail + 1'b1);   // lowest free tag
                    w_gnt[i]      = 1'b1;
                    w_gnt_tag[i]  = pick;
                    w_slot_dep[i] = r_b_mask | w_taken;
                    w_taken       = w_taken | pick;
                    avail         = avail & ~pick;
                end else begin
                    denied       = 1'b1;
                    w_stall_slot = SLOT_W'(i);
                end
            end
        end
        if (w_block) begin
            w_gnt     = '0;
            w_gnt_tag = '0;
            w_taken   = '0;
        end
        if (reset) w_stall_slot = SLOT_W'(N);
    end

    assign w_b_mask_next = (r_b_mask & ~w_clear & ~w_kill) | w_taken;

    always_comb begin
        for (int j = 0; j < BM_W; j++) begin
            w_dep_next[j] = w_kill[j] ? '0 : (r_dep[j] & ~w_clear & ~w_kill);
            for (int i = 0; i < N; i++) begin
                if (w_gnt_tag[i][j]) w_dep_next[j] = w_slot_dep[i] & ~w_clear;
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_b_mask        <= '0;
            r_restore_valid <= 1'b0;
            r_restore_tag   <= '0;
            r_squash_mask   <= '0;
            r_clear_mask    <= '0;
            for (int j = 0; j < BM_W; j++) r_dep[j] <= '0;
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_b_mask        <= w_b_mask_next;
            r_restore_valid <= w_mispred;
            r_restore_tag   <= w_mispred ? io_bus.resolve_tag : '0;
            r_squash_mask   <= w_kill;
            r_clear_mask    <= w_clear;
            for (int j = 0; j < BM_W; j++) r_dep[j] <= w_dep_next[j];
        end
    end

    assign io_bus.br_gnt         = w_gnt;
    assign io_bus.gnt_tag        = w_gnt_tag;
    assign io_bus.tag_stall_slot = w_stall_slot;
    assign io_bus.b_mask         = r_b_mask;
    assign io_bus.restore_valid  = r_restore_valid;
    assign io_bus.restore_tag    = r_restore_tag;
    assign io_bus.squash_mask    = r_squash_mask;
    assign io_bus.clear_mask     = r_clear_mask;
    assign io_bus.dispatch_stall = w_dispatch_stall;

`ifdef BR_TAG_STATS_EN
    logic [31:0] r_stat_full_cycles;
    logic [15:0] r_stat_recoveries;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_full_cycles <= '0;
            r_stat_recoveries  <= '0;
        end else begin
            if ((w_stall_slot < SLOT_W'(N)) && (io_bus.br_req != '0)
                && (r_stat_full_cycles != '1))
                r_stat_full_cycles <= r_stat_full_cycles + 1'b1;
            if (r_restore_valid && (r_stat_recoveries != '1))
                r_stat_recoveries <= r_stat_recoveries + 1'b1;
        end
    end

    assign o_stat_full_cycles = r_stat_full_cycles;
    assign o_stat_recoveries  = r_stat_recoveries;
`endif
endmodule
